// File: rtl/key_pkg.sv
// Shared definitions for the key debounce block: per-channel FSM state
// encoding and the default debounce interval.
package key_pkg;

  typedef enum logic [1:0] {
    KS_IDLE        = 2'd0,
    KS_PRESS_CHK   = 2'd1,
    KS_HELD        = 2'd2,
    KS_RELEASE_CHK = 2'd3
  } key_state_e;

  // 20 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, stability counter and debounce FSM.
// Input is already normalised so that 1 means pressed.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_r;
  logic          synced_s;
  key_state_e    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          level_r, level_s;
  logic          press_r, press_s;
  logic          release_r, release_s;

  assign synced_s = sync_r[1];

  // Two-flop synchroniser for the asynchronous pad level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], key_in};
    end
  end

  // FSM, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= KS_IDLE;
      cnt_r     <= CNT_ZERO;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      level_r   <= level_s;
      press_r   <= press_s;
      release_r <= release_s;
    end
  end

  // Next-state: any opposite sample during a check restarts it; pulses
  // default low so they last exactly one cycle.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    level_s   = level_r;
    press_s   = 1'b0;
    release_s = 1'b0;
    case (state_r)
      KS_IDLE: begin
        if (synced_s) begin
          state_s = KS_PRESS_CHK;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s   = CNT_ZERO;
        end
      end
      KS_PRESS_CHK: begin
        if (!synced_s) begin
          state_s = KS_IDLE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_s = KS_HELD;
          cnt_s   = CNT_ZERO;
          level_s = 1'b1;
          press_s = 1'b1;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      KS_HELD: begin
        if (!synced_s) begin
          state_s = KS_RELEASE_CHK;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = KS_HELD;
        end
      end
      KS_RELEASE_CHK: begin
        if (synced_s) begin
          state_s = KS_HELD;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_s   = KS_IDLE;
          cnt_s     = CNT_ZERO;
          level_s   = 1'b0;
          release_s = 1'b1;
        end else begin
          cnt_s     = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = KS_IDLE;
        cnt_s   = CNT_ZERO;
        level_s = 1'b0;
      end
    endcase
  end

  assign key_level   = level_r;
  assign key_press   = press_r;
  assign key_release = release_r;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: normalises pad polarity to 1 = pressed and runs one
// independent debounce channel per key.
module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam logic [NUM_KEYS-1:0] POLARITY = {NUM_KEYS{KEY_ACTIVE_LOW}};

  logic [NUM_KEYS-1:0] key_norm_s;

  assign key_norm_s = key_in ^ POLARITY;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .key_in     (key_norm_s[g]),
      .key_level  (key_level[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus queues expected pulses with
// their edge number; a negedge monitor matches every pulse the DUT emits.
module tb_key_debounce;

  localparam int NK = 2;
  localparam int DB = 4;
  localparam int LAT = DB + 2;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] level;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t mon_e;

  key_debounce #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int off, input logic [1:0] p, input logic [1:0] r,
                      input logic [1:0] l);
    exp_t e;
    e.cyc = cyc + off;
    e.press = p;
    e.rel = r;
    e.level = l;
    q.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && ((key_press | key_release) != 2'b00)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse cyc %0d press %b release %b", cyc, key_press, key_release);
      end else begin
        mon_e = q.pop_front();
        cmp("pulse_cycle", cyc, mon_e.cyc);
        cmp("key_press", int'(key_press), int'(mon_e.press));
        cmp("key_release", int'(key_release), int'(mon_e.rel));
        cmp("key_level", int'(key_level), int'(mon_e.level));
      end
    end
  end

  initial begin
    reset = 1'b0;
    key_in = 2'b11;
    tick(3);
    cmp("rst_level", int'(key_level), 0);
    cmp("rst_press", int'(key_press), 0);
    cmp("rst_release", int'(key_release), 0);

    reset = 1'b1;
    tick(20);
    cmp("idle_level", int'(key_level), 0);

    // Clean press and release on key 0
    key_in = 2'b10;
    push(LAT, 2'b01, 2'b00, 2'b01);
    tick(LAT - 1);
    cmp("pre_press_level", int'(key_level), 0);
    tick(5);
    key_in = 2'b11;
    push(LAT, 2'b00, 2'b01, 2'b00);
    tick(10);

    // Short glitches are rejected
    for (int i = 0; i < 5; i++) begin
      key_in = 2'b10;
      tick(2);
      key_in = 2'b11;
      tick(2);
    end
    tick(10);
    cmp("glitch_level", int'(key_level), 0);

    // Bouncing press yields a single pulse from the final transition
    key_in = 2'b10; tick(1);
    key_in = 2'b11; tick(1);
    key_in = 2'b10; tick(2);
    key_in = 2'b11; tick(1);
    key_in = 2'b10;
    push(LAT, 2'b01, 2'b00, 2'b01);
    tick(10);
    key_in = 2'b11;
    push(LAT, 2'b00, 2'b01, 2'b00);
    tick(10);

    // Both keys together, then release key 1 only
    key_in = 2'b00;
    push(LAT, 2'b11, 2'b00, 2'b11);
    tick(10);
    key_in = 2'b10;
    push(LAT, 2'b00, 2'b10, 2'b01);
    tick(10);
    key_in = 2'b11;
    push(LAT, 2'b00, 2'b01, 2'b00);
    tick(10);

    // Reset during PRESS_CHK with key 1 held
    key_in = 2'b01;
    tick(4);
    reset = 1'b0;
    #1;
    cmp("rst_chk_level", int'(key_level), 0);
    cmp("rst_chk_press", int'(key_press), 0);
    tick(2);
    reset = 1'b1;
    push(LAT, 2'b10, 2'b00, 2'b10);
    tick(10);
    cmp("held_level", int'(key_level), 2);

    // Reset while HELD drops level asynchronously
    reset = 1'b0;
    #1;
    cmp("rst_held_level", int'(key_level), 0);
    tick(2);
    reset = 1'b1;
    push(LAT, 2'b10, 2'b00, 2'b10);
    tick(10);
    key_in = 2'b11;
    push(LAT, 2'b00, 2'b10, 2'b00);
    tick(10);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses got %0d outstanding want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Upstream conditioning stage for the flow-LED block.
- Takes raw mechanical push-button levels (start/stop keys) and synchronises them to clk.
- Debounces each key independently.
- Emits a clean held level plus single-cycle press and release pulses; the flow-LED block consumes these as its start/reset strobes.
- Replaces direct use of raw pad edges as clocks.

Parameters:
- NUM_KEYS, 2, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, cycles a new level must be stable before acceptance (20 ms at 50 MHz); legal minimum 2.
- KEY_ACTIVE_LOW, 1, 1 = raw pad reads 0 when pressed; 0 = reads 1 when pressed.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- key_in  input  NUM_KEYS  raw asynchronous key pads.
- key_level  output  NUM_KEYS  debounced level, 1 = pressed.
- key_press  output  NUM_KEYS  1-cycle pulse on accepted press.
- key_release  output  NUM_KEYS  1-cycle pulse on accepted release.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous assert, active-low; deassertion is assumed synchronous to clk by the board reset logic.
- Input normalisation: key_in XOR {NUM_KEYS{KEY_ACTIVE_LOW}}, giving 1 = pressed; then a 2-flop synchroniser per bit.
- Reset values: synchroniser flops 0, all FSMs IDLE, counters 0, key_level/key_press/key_release all 0.
- Per-channel FSM, 2-bit state, counter width $clog2(DEBOUNCE_CYCLES+1):
  - IDLE (released, stable): synced=1 -> PRESS_CHK, cnt=1; else stay, cnt=0.
  - PRESS_CHK: synced=0 -> IDLE, cnt=0, no pulse (glitch rejected). synced=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, key_level<=1, key_press<=1. Otherwise cnt+1.
  - HELD: synced=0 -> RELEASE_CHK, cnt=1; else stay.
  - RELEASE_CHK: synced=1 -> HELD, cnt=0, no pulse. synced=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, key_level<=0, key_release<=1. Otherwise cnt+1.
- Outputs: all registered. key_press and key_release are high for exactly one cycle and deassert on the next edge unconditionally.
- Latency: for a clean raw edge, key_press/key_release goes high after the (DEBOUNCE_CYCLES+2)-th rising clk edge following the raw change. Breakdown: 2 synchroniser edges + DEBOUNCE_CYCLES stable samples. key_level changes on the same edge.
- Bounce: any opposite-level sample during a CHK state aborts the check and restarts from 0 on the next qualifying sample. A bouncing key therefore produces exactly one pulse, counted from its last transition.
- Counter: saturating is not required, because cnt never exceeds DEBOUNCE_CYCLES-1. No wrap-around path exists.
- Simultaneous events: channels are fully independent. Pulses on several bits in the same cycle are legal and must all appear.
- Reset mid-operation: any state aborts to IDLE with outputs forced 0 and no pulses emitted.
  - A key still held when reset releases is treated as a new press: key_press fires DEBOUNCE_CYCLES+2 cycles after reset deassertion.
- key_press and key_release are never high together on the same bit.

Decomposition:
- Shared package key_pkg holds:
  - State encoding constants: KS_IDLE=2'd0, KS_PRESS_CHK=2'd1, KS_HELD=2'd2, KS_RELEASE_CHK=2'd3.
  - DEFAULT_DEBOUNCE_CYCLES=1000000.
- One sub-module, key_debounce_ch: a single channel containing synchroniser, counter and FSM, with scalar ports and the same parameters except NUM_KEYS.
- key_debounce does polarity normalisation and generate-instantiates NUM_KEYS copies of key_debounce_ch.

Test Plan (bench uses DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1, NUM_KEYS=2):
- Reset held low, key_in=2'b11 -> all outputs 0. Release reset with keys idle for 20 cycles -> no pulses, key_level=2'b00.
- key_in[0] 1->0, held clean -> key_press[0]=1 for exactly one cycle after the 6th edge. key_level[0]=1 from the same edge. key_in[0] back to 1 -> key_release[0] one cycle after the 6th edge, key_level[0]=0.
- key_in[0] low pulses of 2 cycles, repeated 5 times separated by 2 cycles high -> zero key_press pulses, key_level[0] stays 0.
- Bouncing press (low 1, high 1, low 2, high 1, then low steady) -> exactly one key_press[0], 6 edges after the final 1->0 transition.
- Both keys pressed on the same edge -> key_press=2'b11 in the same cycle. Release only key 1 -> key_release=2'b10, key_level=2'b01.
- key_in[1] held low, reset asserted mid-PRESS_CHK and again while HELD -> outputs drop to 0 asynchronously. After reset release, key_press[1] fires 6 edges later, once.
